// File: rtl/rv_alu_arb.sv
// Two-port arbiter in front of a shared combinational rv_alu, with a single-entry
// response register and saturating per-port grant counters.
module rv_alu_arb #(
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,

  output logic [3:0]       alu_op,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  input  logic [31:0]      alu_rd,
  input  logic             alu_zero,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic             rsp_err,

  input  logic             cnt_clr,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [3:0]       OP_LAST = 4'd9;

  state_t state;
  logic   ptr;
  logic   any_valid;
  logic   accept;
  logic   grant_id;
  logic   op_illegal;

  assign rsp_valid = (state == FULL);

  // Reset blocks acceptance so no requester sees ready while a response is discarded.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    accept    = any_valid && ((state == EMPTY) || rsp_ready) && !rst;

    if (req0_valid && req1_valid) begin
      grant_id = (FIXED_PRIO != 0) ? 1'b0 : ptr;
    end else begin
      grant_id = req1_valid;
    end

    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;

    if (accept && grant_id) begin
      alu_op  = req1_op;
      alu_rs1 = req1_a;
      alu_rs2 = req1_b;
    end else begin
      alu_op  = req0_op;
      alu_rs1 = req0_a;
      alu_rs2 = req0_b;
    end

    op_illegal = (alu_op > OP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      ptr        <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (accept) begin
        state    <= FULL;
        rsp_data <= op_illegal ? 32'd0 : alu_rd;
        rsp_zero <= !op_illegal && alu_zero;
        rsp_id   <= grant_id;
        rsp_err  <= op_illegal;
        ptr      <= ~grant_id;
      end else if ((state == FULL) && rsp_ready) begin
        state <= EMPTY;
      end

      // Clear wins over a same-cycle increment; counters stick at all-ones.
      if (cnt_clr) begin
        grant_cnt0 <= '0;
        grant_cnt1 <= '0;
      end else if (accept) begin
        if (!grant_id && (grant_cnt0 != CNT_MAX)) begin
          grant_cnt0 <= grant_cnt0 + CNT_ONE;
        end
        if (grant_id && (grant_cnt1 != CNT_MAX)) begin
          grant_cnt1 <= grant_cnt1 + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_alu_arb.sv
// Self-checking bench for rv_alu_arb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_rv_alu_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_ready = 1'b0, cnt_clr = 1'b0;

  logic        req0_ready, req1_ready, rsp_valid, rsp_zero, rsp_id, rsp_err;
  logic [3:0]  alu_op;
  logic [31:0] alu_rs1, alu_rs2, alu_rd, rsp_data;
  logic        alu_zero;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_zero, fp_rsp_id, fp_rsp_err;
  logic [3:0]  fp_alu_op;
  logic [31:0] fp_alu_rs1, fp_alu_rs2, fp_alu_rd, fp_rsp_data;
  logic        fp_alu_zero;
  logic [1:0]  fp_cnt0, fp_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU; illegal opcodes return garbage so sampling them is visible.
  function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a ^ b;
      4'd3: r = a | b;
      4'd4: r = a & b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = 32'($signed(a) >>> b[4:0]);
      4'd8: r = {31'd0, ($signed(a) < $signed(b))};
      4'd9: r = {31'd0, (a < b)};
      default: return {1'b1, 32'hDEADBEEF};
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_rd}       = alu_fn(alu_op, alu_rs1, alu_rs2);
  assign {fp_alu_zero, fp_alu_rd} = alu_fn(fp_alu_op, fp_alu_rs1, fp_alu_rs2);

  rv_alu_arb #(.FIXED_PRIO(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .cnt_clr(cnt_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  rv_alu_arb #(.FIXED_PRIO(1), .CNT_W(2)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(fp_alu_op), .alu_rs1(fp_alu_rs1), .alu_rs2(fp_alu_rs2), .alu_rd(fp_alu_rd), .alu_zero(fp_alu_zero),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data), .rsp_zero(fp_rsp_zero),
    .rsp_id(fp_rsp_id), .rsp_err(fp_rsp_err),
    .cnt_clr(cnt_clr), .grant_cnt0(fp_cnt0), .grant_cnt1(fp_cnt1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic rr, input logic clr, input logic rs);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready = rr; cnt_clr = clr; rst = rs;
  endtask

  task automatic idle(input logic rr, input logic clr, input logic rs);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, rr, clr, rs);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Transaction-level model: one response slot, a "next preferred port" flag, two counters.
  logic m_full, m_zero, m_id, m_err, m_ptr, started = 1'b0;
  logic [31:0] m_data;
  int m_cnt0, m_cnt1;

  always @(negedge clk) begin : compare
    logic acc, win;
    logic [3:0] xop;
    logic [31:0] xa, xb;
    logic [32:0] res;
    if (started) begin
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full) begin
        checkOutput("rsp_data", rsp_data, m_data);
        checkOutput("rsp_zero", 32'(rsp_zero), 32'(m_zero));
        checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
        checkOutput("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      checkOutput("grant_cnt0", 32'(grant_cnt0), m_cnt0);
      checkOutput("grant_cnt1", 32'(grant_cnt1), m_cnt1);
    end
    acc = !rst && (req0_valid || req1_valid) && (!m_full || rsp_ready);
    win = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    xop = (acc && win) ? req1_op : req0_op;
    xa  = (acc && win) ? req1_a  : req0_a;
    xb  = (acc && win) ? req1_b  : req0_b;
    if (started || rst) begin
      checkOutput("req0_ready", 32'(req0_ready), 32'(acc && !win));
      checkOutput("req1_ready", 32'(req1_ready), 32'(acc && win));
      checkOutput("alu_op", 32'(alu_op), 32'(xop));
      checkOutput("alu_rs1", alu_rs1, xa);
      checkOutput("alu_rs2", alu_rs2, xb);
    end
    if (rst) begin
      m_full = 0; m_data = 0; m_zero = 0; m_id = 0; m_err = 0; m_ptr = 0;
      m_cnt0 = 0; m_cnt1 = 0;
      started = 1'b1;
    end else begin
      if (acc) begin
        res    = alu_fn(xop, xa, xb);
        m_err  = (xop > 4'd9);
        m_data = m_err ? 32'd0 : res[31:0];
        m_zero = m_err ? 1'b0 : res[32];
        m_id   = win;
        m_ptr  = !win;
        m_full = 1'b1;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
      if (cnt_clr) begin
        m_cnt0 = 0; m_cnt1 = 0;
      end else if (acc) begin
        if (!win) m_cnt0 = (m_cnt0 == 65535) ? 65535 : m_cnt0 + 1;
        else      m_cnt1 = (m_cnt1 == 65535) ? 65535 : m_cnt1 + 1;
      end
    end
  end

  initial begin
    idle(1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_rsp_flags", {29'd0, rsp_zero, rsp_id, rsp_err}, 32'd0);
    checkOutput("reset_cnt", {grant_cnt0, grant_cnt1}, 32'd0);

    // Single ADD, then backpressure while port 1 waits.
    applyStimulus(1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("add_req0_ready", 32'(req0_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
      settle();
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_data", rsp_data, 32'd12);
      checkOutput("bp_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("bp_req1_ready", 32'(req1_ready), 32'd0);
    end
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("bp_release_req1_ready", 32'(req1_ready), 32'd1);
    idle(1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("bp_new_data", rsp_data, 32'd3);
    checkOutput("bp_new_id", 32'(rsp_id), 32'd1);
    idle(1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("drain_rsp_valid", 32'(rsp_valid), 32'd0);

    // Contention: round-robin on dut, port 0 always on dut_fp (2-bit counters).
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'd0, i, 32'd0, 1'b1, 4'd0, i, 32'd100, 1'b1, 1'b0, 1'b0);
      settle();
      checkOutput("rr_req0_ready", 32'(req0_ready), 32'((i % 2) == 0));
      checkOutput("rr_req1_ready", 32'(req1_ready), 32'((i % 2) == 1));
      checkOutput("fp_req0_ready", 32'(fp_req0_ready), 32'd1);
      checkOutput("fp_req1_ready", 32'(fp_req1_ready), 32'd0);
    end
    idle(1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("rr_cnt0", 32'(grant_cnt0), 32'd2);
    checkOutput("rr_cnt1", 32'(grant_cnt1), 32'd2);
    checkOutput("rr_last_data", rsp_data, 32'd103);
    checkOutput("fp_cnt0_sat", 32'(fp_cnt0), 32'd3);
    checkOutput("fp_cnt1", 32'(fp_cnt1), 32'd0);

    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'hC, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("ill_req1_ready", 32'(req1_ready), 32'd1);
    idle(1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("ill_rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("ill_rsp_data", rsp_data, 32'd0);
    checkOutput("ill_rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("ill_rsp_zero", 32'(rsp_zero), 32'd0);

    applyStimulus(1'b1, 4'd1, 32'd9, 32'd9, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd8, 32'hFFFFFFFF, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("sub_zero", 32'(rsp_zero), 32'd1);
    checkOutput("sub_data", rsp_data, 32'd0);
    checkOutput("sub_err", 32'(rsp_err), 32'd0);
    idle(1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("slt_data", rsp_data, 32'd1);

    // Saturation, then reset while FULL with both ports requesting.
    idle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 4'd0, 32'd1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 4'd0, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("sat_fp_cnt0", 32'(fp_cnt0), 32'd3);
    checkOutput("sat_cnt0", 32'(grant_cnt0), 32'd5);
    applyStimulus(1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 4'd0, 32'd2, 32'd2, 1'b1, 1'b0, 1'b1);
    settle();
    checkOutput("rst_req_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    idle(1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_cnt", {grant_cnt0, grant_cnt1}, 32'd0);
    checkOutput("rst_fp_cnt", {28'd0, fp_cnt0, fp_cnt1}, 32'd0);

    applyStimulus(1'b1, 4'd0, 32'd4, 32'd4, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("clr_over_inc_cnt0", 32'(grant_cnt0), 32'd0);
    checkOutput("clr_over_inc_valid", 32'(rsp_valid), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a0, b0, a1, b1;
      a0 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      b0 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      a1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      b1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), a0, b0,
                    $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), a1, b1,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                    $urandom_range(0, 63) == 0);
    end
    idle(1'b1, 1'b0, 1'b0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
